// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the bit-serial subtractor.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Requester side: issues operands and start, observes status and result.
  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  // Subtractor side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtract cell plus a borrow flop,
// LSB first, WIDTH+1 cycles from accepted start to the done pulse.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH-1:0] res_q;
  logic             bor_q;
  logic [CntW-1:0]  cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  logic             bit_x;
  logic             bit_y;
  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] res_next;

  // Full-subtract cell: two half-subtract stages with their borrows ORed.
  always_comb begin
    bit_x    = sa_q[0];
    bit_y    = sb_q[0];
    bit_d    = bit_x ^ bit_y ^ bor_q;
    bit_bout = (~bit_x & bit_y) | (~(bit_x ^ bit_y) & bor_q);
    res_next = {bit_d, res_q[WIDTH-1:1]};
  end

  // Control FSM with datapath and registered status/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      bor_q    <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        // DONE accepts start exactly like IDLE so back-to-back runs lose no cycle.
        StIdle, StDone: begin
          if (bus.start) begin
            sa_q    <= bus.a;
            sb_q    <= bus.b;
            bor_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StShift;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StShift: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          res_q <= res_next;
          bor_q <= bit_bout;
          cnt_q <= cnt_q + CntW'(1);
          // Last bit: publish the completed result alongside the done pulse.
          if (cnt_q == LastCnt) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            diff_q   <= res_next;
            borrow_q <= bit_bout;
            state_q  <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized self-checking bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [W-1:0] held_d;
  logic         held_b;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation; poke>0 pulses a stray start that many edges into the run.
  task automatic run_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b, input int poke);
    logic [W-1:0] exp_d;
    logic         exp_b;
    exp_d = W'(op_a - op_b);
    exp_b = (op_a < op_b);
    bus.start = 1'b1;
    bus.a     = op_a;
    bus.b     = op_b;
    tick();
    bus.start = 1'b0;
    bus.a     = W'($urandom);
    bus.b     = W'($urandom);
    for (int k = 1; k <= int'(W); k++) begin
      check("busy_run", 32'(bus.busy), 32'(1));
      check("done_early", 32'(bus.done), 32'(0));
      check("diff_held", 32'(bus.diff), 32'(held_d));
      check("borrow_held", 32'(bus.borrow), 32'(held_b));
      if (k == poke) begin
        bus.start = 1'b1;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end
      tick();
      bus.start = 1'b0;
    end
    check("done_pulse", 32'(bus.done), 32'(1));
    check("busy_at_done", 32'(bus.busy), 32'(0));
    check("diff", 32'(bus.diff), 32'(exp_d));
    check("borrow", 32'(bus.borrow), 32'(exp_b));
    held_d = exp_d;
    held_b = exp_b;
    tick();
    check("done_width", 32'(bus.done), 32'(0));
    check("busy_after", 32'(bus.busy), 32'(0));
    check("diff_keep", 32'(bus.diff), 32'(held_d));
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    held_d    = '0;
    held_b    = 1'b0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.a     = 8'h12;
    bus.b     = 8'h34;
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_diff", 32'(bus.diff), 32'(0));
    check("rst_borrow", 32'(bus.borrow), 32'(0));
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();

    // Directed cases.
    run_op(8'h5A, 8'h23, 0);
    run_op(8'h23, 8'h5A, 0);
    run_op(8'h00, 8'h01, 0);
    run_op(8'hAA, 8'hAA, 0);
    run_op(8'hFF, 8'h00, 0);
    tick();
    tick();
    run_op(8'h80, 8'h7F, 3);

    // Abort mid-run with reset: no done, outputs cleared.
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h44;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_diff", 32'(bus.diff), 32'(0));
    check("abort_borrow", 32'(bus.borrow), 32'(0));
    check("abort_busy", 32'(bus.busy), 32'(0));
    held_d = '0;
    held_b = 1'b0;
    for (int k = 0; k < 12; k++) begin
      check("abort_no_done", 32'(bus.done), 32'(0));
      tick();
    end
    run_op(8'h10, 8'h01, 0);

    // Start held high: one result every W+1 cycles.
    bus.start = 1'b1;
    bus.a     = 8'h3C;
    bus.b     = 8'h5D;
    for (int k = 0; k < 4 * int'(W + 1); k++) begin
      tick();
      check("b2b_done", 32'(bus.done), 32'((k % int'(W + 1)) == int'(W)));
      check("b2b_nooverlap", 32'(bus.busy & bus.done), 32'(0));
      if (bus.done) begin
        check("b2b_diff", 32'(bus.diff), 32'(8'hDF));
        check("b2b_borrow", 32'(bus.borrow), 32'(1));
      end
    end
    bus.start = 1'b0;
    held_d    = 8'hDF;
    held_b    = 1'b1;
    tick();
    check("b2b_idle", 32'(bus.busy), 32'(0));

    // Random sweep.
    for (int n = 0; n < 1000; n++) begin
      run_op(W'($urandom), W'($urandom), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
